dff_timing_guard: RTL and testbench

DFF_TIMING_GUARD -- requirements
Module: dff_timing_guard

---
 rtl/dff_timing_guard.sv | 179 +++++++++++++++++
 tb/tb_dff_timing_guard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_timing_guard.sv
// dff_timing_guard: per-channel flip-flop model with timing checks.
// Each channel captures its raw inputs into a sampling register, filters d
// against minimum high/low times, qualifies set/reset requests against a
// minimum pulse width, and drives q through a fixed propagation pipeline.
// Short d pulses and short set/reset pulses raise sticky violation flags.
module dff_timing_guard #(
  parameter int N_CH       = 4,
  parameter int PULSE_MIN  = 12,
  parameter int D_HIGH_MIN = 16,
  parameter int D_LOW_MIN  = 3,
  parameter int PROP_DLY   = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] d,
  input  logic [N_CH-1:0] ch_set,
  input  logic [N_CH-1:0] ch_res,
  input  logic            clr_viol,
  output logic [N_CH-1:0] q,
  output logic [N_CH-1:0] viol_glitch,
  output logic [N_CH-1:0] viol_pulse
);

  localparam logic [5:0] CNT_MAX    = 6'd63;
  localparam logic [5:0] PULSE_LAST = 6'(PULSE_MIN - 1);
  localparam logic [5:0] PULSE_LIM  = 6'(PULSE_MIN);
  localparam logic [5:0] HIGH_LAST  = 6'(D_HIGH_MIN - 1);
  localparam logic [5:0] LOW_LAST   = 6'(D_LOW_MIN - 1);

  // Saturating 6-bit increment shared by all run counters.
  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + 6'd1;
    end
  endfunction

  // Input sampling stage (all timing checks work on these copies).
  logic [N_CH-1:0] d_in_q, set_in_q, res_in_q;

  // Filter, qualifier and flag state.
  logic [N_CH-1:0] d_f_q, d_f_d;
  logic [5:0]      dcnt_q [N_CH];
  logic [5:0]      dcnt_d [N_CH];
  logic [5:0]      scnt_q [N_CH];
  logic [5:0]      scnt_d [N_CH];
  logic [5:0]      rcnt_q [N_CH];
  logic [5:0]      rcnt_d [N_CH];
  logic [N_CH-1:0] q_int_q, q_int_d;
  logic [N_CH-1:0] vg_q, vg_d;
  logic [N_CH-1:0] vp_q, vp_d;

  // Per-channel combinational helpers.
  logic [5:0]      th_last_s [N_CH];
  logic [N_CH-1:0] glitch_s;
  logic [N_CH-1:0] set_fall_s, res_fall_s;
  logic [N_CH-1:0] set_ok_s, rst_ok_s;

  // Next-state logic for filters, counters, internal q and sticky flags.
  always_comb begin
    d_f_d      = d_f_q;
    q_int_d    = q_int_q;
    glitch_s   = {N_CH{1'b0}};
    set_fall_s = {N_CH{1'b0}};
    res_fall_s = {N_CH{1'b0}};
    set_ok_s   = {N_CH{1'b0}};
    rst_ok_s   = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      dcnt_d[i]    = dcnt_q[i];
      scnt_d[i]    = scnt_q[i];
      rcnt_d[i]    = rcnt_q[i];
      th_last_s[i] = d_f_q[i] ? LOW_LAST : HIGH_LAST;

      // d filter: accept a new level only after it has been stable long enough.
      if (d_in_q[i] != d_f_q[i]) begin
        if (dcnt_q[i] == th_last_s[i]) begin
          d_f_d[i]  = d_in_q[i];
          dcnt_d[i] = 6'd0;
        end else begin
          dcnt_d[i] = sat_inc(dcnt_q[i]);
        end
      end else begin
        dcnt_d[i]   = 6'd0;
        glitch_s[i] = (dcnt_q[i] != 6'd0) && (dcnt_q[i] <= th_last_s[i]);
      end

      // Set request width counter; a nonzero count while low marks the fall.
      if (set_in_q[i]) begin
        scnt_d[i] = sat_inc(scnt_q[i]);
      end else begin
        scnt_d[i]     = 6'd0;
        set_fall_s[i] = (scnt_q[i] != 6'd0) && (scnt_q[i] < PULSE_LIM);
      end

      // Reset request width counter, same scheme as set.
      if (res_in_q[i]) begin
        rcnt_d[i] = sat_inc(rcnt_q[i]);
      end else begin
        rcnt_d[i]     = 6'd0;
        res_fall_s[i] = (rcnt_q[i] != 6'd0) && (rcnt_q[i] < PULSE_LIM);
      end

      set_ok_s[i] = set_in_q[i] && (scnt_q[i] >= PULSE_LAST);
      rst_ok_s[i] = res_in_q[i] && (rcnt_q[i] >= PULSE_LAST);

      // Reset wins over set; otherwise follow the freshly filtered d.
      if (rst_ok_s[i]) begin
        q_int_d[i] = 1'b0;
      end else if (set_ok_s[i]) begin
        q_int_d[i] = 1'b1;
      end else begin
        q_int_d[i] = d_f_d[i];
      end
    end
    // A violation seen on the clearing edge survives the clear.
    vg_d = (clr_viol ? {N_CH{1'b0}} : vg_q) | glitch_s;
    vp_d = (clr_viol ? {N_CH{1'b0}} : vp_q) | set_fall_s | res_fall_s;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_in_q   <= {N_CH{1'b0}};
      set_in_q <= {N_CH{1'b0}};
      res_in_q <= {N_CH{1'b0}};
      d_f_q    <= {N_CH{1'b0}};
      q_int_q  <= {N_CH{1'b0}};
      vg_q     <= {N_CH{1'b0}};
      vp_q     <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        dcnt_q[i] <= 6'd0;
        scnt_q[i] <= 6'd0;
        rcnt_q[i] <= 6'd0;
      end
    end else begin
      d_in_q   <= d;
      set_in_q <= ch_set;
      res_in_q <= ch_res;
      d_f_q    <= d_f_d;
      q_int_q  <= q_int_d;
      vg_q     <= vg_d;
      vp_q     <= vp_d;
      for (int i = 0; i < N_CH; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        scnt_q[i] <= scnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  assign viol_glitch = vg_q;
  assign viol_pulse  = vp_q;

  generate
    if (PROP_DLY == 0) begin : g_nodly
      assign q = q_int_q;
    end else begin : g_dly
      logic [N_CH-1:0] dly_q [PROP_DLY];

      // Propagation delay pipeline, cleared by reset.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int s = 0; s < PROP_DLY; s++) begin
            dly_q[s] <= {N_CH{1'b0}};
          end
        end else begin
          dly_q[0] <= q_int_q;
          for (int s = 1; s < PROP_DLY; s++) begin
            dly_q[s] <= dly_q[s-1];
          end
        end
      end

      assign q = dly_q[PROP_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_dff_timing_guard.sv
// Directed testbench for dff_timing_guard: default 4-channel instance plus a
// 1-channel zero-propagation-delay instance sharing clock, reset and clr_viol.
module tb_dff_timing_guard;

  logic       clock;
  logic       reset;
  logic       clr_viol;
  logic [3:0] d, ch_set, ch_res;
  logic [3:0] q, vg, vp;
  logic [0:0] d1, set1, res1;
  logic [0:0] q1, vg1, vp1;

  int checks;
  int errors;

  dff_timing_guard #(
    .N_CH(4), .PULSE_MIN(12), .D_HIGH_MIN(16), .D_LOW_MIN(3), .PROP_DLY(2)
  ) dut (
    .clock(clock), .reset(reset), .d(d), .ch_set(ch_set), .ch_res(ch_res),
    .clr_viol(clr_viol), .q(q), .viol_glitch(vg), .viol_pulse(vp)
  );

  dff_timing_guard #(
    .N_CH(1), .PULSE_MIN(12), .D_HIGH_MIN(16), .D_LOW_MIN(3), .PROP_DLY(0)
  ) dut1 (
    .clock(clock), .reset(reset), .d(d1), .ch_set(set1), .ch_res(res1),
    .clr_viol(clr_viol), .q(q1), .viol_glitch(vg1), .viol_pulse(vp1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One active edge, then settle before looking at outputs or driving inputs.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clr_viol = 1'b0;
    d = 4'h0; ch_set = 4'h0; ch_res = 4'h0;
    d1 = 1'b0; set1 = 1'b0; res1 = 1'b0;
    tick();
    checks++;
    if (q !== 4'h0 || vg !== 4'h0 || vp !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: q=%b vg=%b vp=%b, required all 0", q, vg, vp);
    end
    checks++;
    if (q1 !== 1'b0 || vg1 !== 1'b0 || vp1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_n1: q=%b vg=%b vp=%b, required all 0", q1, vg1, vp1);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ch0 d high for exactly 16 cycles on both instances; q rises at edge 19
  // (edge 17 without propagation delay) and drops after the 3-cycle low time.
  task automatic test_clean_d();
    logic exp4, exp1;
    d[0] = 1'b1; d1 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 16) begin
        d[0] = 1'b0; d1 = 1'b0;
      end
      exp4 = (k >= 19) && (k <= 21);
      exp1 = (k >= 17) && (k <= 19);
      checks++;
      if (q[0] !== exp4) begin
        errors++;
        $display("FAIL clean_d_q0 edge %0d: got %b, required %b", k, q[0], exp4);
      end
      checks++;
      if (q1 !== exp1) begin
        errors++;
        $display("FAIL clean_d_q_prop0 edge %0d: got %b, required %b", k, q1, exp1);
      end
    end
    checks++;
    if (vg !== 4'h0 || vg1 !== 1'b0) begin
      errors++;
      $display("FAIL clean_d_no_glitch: vg=%b vg1=%b, required 0", vg, vg1);
    end
  endtask

  // ch1 d high for 10 cycles: glitch flagged on edge 12, q stays low; a clear
  // on the detection edge loses, a later clear wins.
  task automatic test_glitch();
    d[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      clr_viol = (k == 12);
      tick();
      clr_viol = 1'b0;
      if (k == 10) d[1] = 1'b0;
      checks++;
      if (q[1] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_q1 edge %0d: got %b, required 0", k, q[1]);
      end
      if (k == 11) begin
        checks++;
        if (vg[1] !== 1'b0) begin
          errors++;
          $display("FAIL glitch_before edge %0d: got %b, required 0", k, vg[1]);
        end
      end
      if (k >= 12) begin
        checks++;
        if (vg !== 4'b0010) begin
          errors++;
          $display("FAIL glitch_flag edge %0d: vg=%b, required 0010", k, vg);
        end
      end
    end
    clr_viol = 1'b1;
    tick();
    clr_viol = 1'b0;
    checks++;
    if (vg !== 4'h0) begin
      errors++;
      $display("FAIL glitch_clear: vg=%b, required 0000", vg);
    end
  endtask

  // ch2 set: 12-cycle pulse gives a one-cycle q high at edge 15; a 5-cycle
  // pulse is flagged on edge 7 and leaves q alone.
  task automatic test_set_pulse();
    logic exp;
    ch_set[2] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 12) ch_set[2] = 1'b0;
      exp = (k == 15);
      checks++;
      if (q[2] !== exp) begin
        errors++;
        $display("FAIL set_long_q2 edge %0d: got %b, required %b", k, q[2], exp);
      end
    end
    checks++;
    if (vp !== 4'h0) begin
      errors++;
      $display("FAIL set_long_no_viol: vp=%b, required 0000", vp);
    end
    ch_set[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) ch_set[2] = 1'b0;
      exp = (k >= 7);
      checks++;
      if (q[2] !== 1'b0 || vp[2] !== exp) begin
        errors++;
        $display("FAIL set_short edge %0d: q2=%b vp2=%b, required q2=0 vp2=%b",
                 k, q[2], vp[2], exp);
      end
    end
  endtask

  // ch3 with d stable high: long simultaneous set and reset resolve to 0.
  task automatic test_set_res();
    logic exp;
    d[3] = 1'b1;
    for (int k = 1; k <= 20; k++) tick();
    checks++;
    if (q[3] !== 1'b1) begin
      errors++;
      $display("FAIL setres_pre_q3: got %b, required 1", q[3]);
    end
    ch_set[3] = 1'b1; ch_res[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = (k < 15);
      checks++;
      if (q[3] !== exp) begin
        errors++;
        $display("FAIL setres_hold_q3 edge %0d: got %b, required %b", k, q[3], exp);
      end
    end
    ch_set[3] = 1'b0; ch_res[3] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 2 || k >= 5) begin
        exp = (k >= 5);
        checks++;
        if (q[3] !== exp) begin
          errors++;
          $display("FAIL setres_release_q3 edge %0d: got %b, required %b", k, q[3], exp);
        end
      end
    end
    checks++;
    if (vp[3] !== 1'b0 || vg[3] !== 1'b0) begin
      errors++;
      $display("FAIL setres_no_viol: vp3=%b vg3=%b, required 0", vp[3], vg[3]);
    end
  endtask

  // Reset at cycle 8 of a 12-cycle set pulse; the post-reset remainder is short.
  task automatic test_reset_mid_pulse();
    logic exp;
    ch_set[2] = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    checks++;
    if (q[3] !== 1'b1 || vp[2] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: q3=%b vp2=%b, required 1 1", q[3], vp[2]);
    end
    reset = 1'b1; d[3] = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if (q !== 4'h0 || vg !== 4'h0 || vp !== 4'h0) begin
      errors++;
      $display("FAIL midrst_clear: q=%b vg=%b vp=%b, required all 0", q, vg, vp);
    end
    for (int k = 9; k <= 16; k++) begin
      tick();
      if (k == 12) ch_set[2] = 1'b0;
      exp = (k >= 14);
      checks++;
      if (vp !== {1'b0, exp, 2'b00} || q !== 4'h0) begin
        errors++;
        $display("FAIL midrst_after edge %0d: vp=%b q=%b, required vp=%b q=0000",
                 k, vp, q, {1'b0, exp, 2'b00});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clean_d();
    test_glitch();
    test_set_pulse();
    test_set_res();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
